// File: rtl/axi_read_arbiter.sv
// Two-master AXI read arbiter: I-cache and D-cache share one AR/R channel pair.
// The grant is round-robin, and only one burst is in flight at a time.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_arvalid,
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic [7:0]            ic_arlen,
  input  logic [2:0]            ic_arsize,
  input  logic [1:0]            ic_arburst,
  output logic                  ic_arready,
  output logic                  ic_rvalid,
  output logic                  ic_rlast,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  input  logic                  ic_rready,
  input  logic                  dc_arvalid,
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic [7:0]            dc_arlen,
  input  logic [2:0]            dc_arsize,
  input  logic [1:0]            dc_arburst,
  output logic                  dc_arready,
  output logic                  dc_rvalid,
  output logic                  dc_rlast,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  input  logic                  dc_rready,
  output logic                  m_axi_arvalid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  output logic                  m_axi_rready,
  output logic                  instruction_cache_reading,
  output logic                  data_cache_reading,
  output logic                  protocol_error
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                r_state, w_next;
  logic                  r_owner;       // 1 = D-cache
  logic                  r_last_grant;  // 1 = D-cache
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;

  logic w_ic_win, w_dc_win, w_grant, w_rready, w_beat;

  // I-cache wins unless the D-cache also asks and the I-cache had the last turn
  assign w_ic_win = ic_arvalid & (~dc_arvalid | r_last_grant);
  assign w_dc_win = dc_arvalid & ~w_ic_win;
  assign w_grant  = (r_state == IDLE) & (ic_arvalid | dc_arvalid);
  assign w_rready = r_owner ? dc_rready : ic_rready;
  assign w_beat   = (r_state == DATA) & m_axi_rvalid & w_rready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = ADDR;
      ADDR:    if (m_axi_arready) w_next = DATA;
      DATA:    if (w_beat && m_axi_rlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner <= w_dc_win;
        r_addr  <= w_dc_win ? dc_araddr  : ic_araddr;
        r_len   <= w_dc_win ? dc_arlen   : ic_arlen;
        r_size  <= w_dc_win ? dc_arsize  : ic_arsize;
        r_burst <= w_dc_win ? dc_arburst : ic_arburst;
      end
      if (r_state == ADDR && m_axi_arready) r_cnt <= r_len;
      if (w_beat) begin
        if (m_axi_rlast) begin
          r_last_grant <= r_owner;
          if (r_cnt != 8'd0) r_err <= 1'b1;
        end else if (r_cnt == 8'd0) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end
    end
  end

  always_comb begin
    ic_arready                = 1'b0;
    dc_arready                = 1'b0;
    ic_rvalid                 = 1'b0;
    ic_rlast                  = 1'b0;
    ic_rdata                  = '0;
    dc_rvalid                 = 1'b0;
    dc_rlast                  = 1'b0;
    dc_rdata                  = '0;
    m_axi_arvalid             = 1'b0;
    m_axi_araddr              = '0;
    m_axi_arlen               = '0;
    m_axi_arsize              = '0;
    m_axi_arburst             = '0;
    m_axi_rready              = 1'b0;
    instruction_cache_reading = 1'b0;
    data_cache_reading        = 1'b0;
    protocol_error            = 1'b0;
    if (!reset) begin
      protocol_error = r_err;
      m_axi_araddr   = r_addr;
      m_axi_arlen    = r_len;
      m_axi_arsize   = r_size;
      m_axi_arburst  = r_burst;
      case (r_state)
        IDLE: begin
          ic_arready = w_ic_win;
          dc_arready = w_dc_win;
        end
        ADDR: begin
          m_axi_arvalid             = 1'b1;
          instruction_cache_reading = ~r_owner;
          data_cache_reading        = r_owner;
        end
        DATA: begin
          instruction_cache_reading = ~r_owner;
          data_cache_reading        = r_owner;
          m_axi_rready              = w_rready;
          if (r_owner) begin
            dc_rvalid = m_axi_rvalid;
            dc_rlast  = m_axi_rlast;
            dc_rdata  = m_axi_rdata;
          end else begin
            ic_rvalid = m_axi_rvalid;
            ic_rlast  = m_axi_rlast;
            ic_rdata  = m_axi_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: the bench drives inputs on the falling edge and samples 1ns later.
module tb_axi_read_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        ic_arvalid = 0, dc_arvalid = 0, ic_rready = 0, dc_rready = 0;
  logic [63:0] ic_araddr = 0, dc_araddr = 0, m_axi_araddr, m_axi_rdata = 0;
  logic [7:0]  ic_arlen = 0, dc_arlen = 0, m_axi_arlen;
  logic [2:0]  ic_arsize = 0, dc_arsize = 0, m_axi_arsize;
  logic [1:0]  ic_arburst = 0, dc_arburst = 0, m_axi_arburst;
  logic        ic_arready, ic_rvalid, ic_rlast, dc_arready, dc_rvalid, dc_rlast;
  logic [63:0] ic_rdata, dc_rdata;
  logic        m_axi_arvalid, m_axi_arready = 0, m_axi_rvalid = 0, m_axi_rlast = 0, m_axi_rready;
  logic        icr, dcr, perr;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arsize(ic_arsize),
    .ic_arburst(ic_arburst), .ic_arready(ic_arready), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
    .ic_rdata(ic_rdata), .ic_rready(ic_rready),
    .dc_arvalid(dc_arvalid), .dc_araddr(dc_araddr), .dc_arlen(dc_arlen), .dc_arsize(dc_arsize),
    .dc_arburst(dc_arburst), .dc_arready(dc_arready), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
    .dc_rdata(dc_rdata), .dc_rready(dc_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready),
    .instruction_cache_reading(icr), .data_cache_reading(dcr), .protocol_error(perr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ar"}, {ic_arready, dc_arready, m_axi_arvalid, m_axi_rready}, 0);
    chk({tag, "_r"}, {ic_rvalid, ic_rlast, dc_rvalid, dc_rlast}, 0);
    chk({tag, "_flags"}, {icr, dcr, perr}, 0);
    chk({tag, "_addr"}, m_axi_araddr, 0);
  endtask

  task automatic set_req(input bit dc, input logic [63:0] a, input logic [7:0] len);
    if (dc) begin dc_arvalid = 1; dc_araddr = a; dc_arlen = len; dc_arsize = 3; dc_arburst = 1; end
    else    begin ic_arvalid = 1; ic_araddr = a; ic_arlen = len; ic_arsize = 3; ic_arburst = 1; end
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk); @(negedge clk);
    #1 chk_all_zero("in_reset");
    @(negedge clk);
    reset = 0;
  endtask

  // Called 1ns after the falling edge of the first ADDR cycle; returns likewise in the first DATA cycle
  task automatic addr_phase(input bit dc, input logic [63:0] a, input logic [7:0] len, input int delay);
    for (int i = 0; i <= delay; i++) begin
      chk("arvalid", m_axi_arvalid, 1);
      chk("araddr", m_axi_araddr, a);
      chk("arlen", m_axi_arlen, len);
      chk("ar_flags", {icr, dcr}, dc ? 2'b01 : 2'b10);
      if (i == delay) m_axi_arready = 1;
      @(negedge clk);
    end
    m_axi_arready = 0;
    #1 chk("arvalid_drop", m_axi_arvalid, 0);
  endtask

  // Delivers beats 0..last; rlast is driven on beat 'last'. Returns in the following cycle.
  task automatic data_phase(input bit dc, input int last);
    ic_rready = !dc; dc_rready = dc;
    for (int i = 0; i <= last; i++) begin
      m_axi_rvalid = 1;
      m_axi_rdata = (dc ? 64'hD000 : 64'hA000) + 64'(i);
      m_axi_rlast = (i == last);
      #1;
      chk("rvalid_own", dc ? dc_rvalid : ic_rvalid, 1);
      chk("rlast_own", dc ? dc_rlast : ic_rlast, (i == last));
      chk("rdata_own", dc ? dc_rdata : ic_rdata, (dc ? 64'hD000 : 64'hA000) + 64'(i));
      chk("r_other", dc ? {ic_rvalid, ic_rlast} : {dc_rvalid, dc_rlast}, 0);
      chk("rready", m_axi_rready, 1);
      chk("r_flags", {icr, dcr}, dc ? 2'b01 : 2'b10);
      chk("ar_busy", {ic_arready, dc_arready}, 0);
      @(negedge clk);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0; dc_rready = 0;
    #1 chk("idle_flags", {icr, dcr, m_axi_arvalid}, 0);
  endtask

  task automatic run_burst(input bit dc, input logic [63:0] a, input logic [7:0] len, input int delay);
    set_req(dc, a, len);
    #1 chk("arready_win", dc ? dc_arready : ic_arready, 1);
    chk("arready_lose", dc ? ic_arready : dc_arready, 0);
    chk("ar_n", m_axi_arvalid, 0);
    @(negedge clk);
    ic_arvalid = 0; dc_arvalid = 0;
    #1 addr_phase(dc, a, len, delay);
    data_phase(dc, int'(len));
  endtask

  initial begin
    // Reset state, including arready suppression with a pending request
    ic_arvalid = 1; ic_rready = 1;
    do_reset();
    ic_arvalid = 0; ic_rready = 0;

    // I-cache alone, 8-beat burst
    run_burst(0, 64'h1000, 8'd7, 0);
    chk("err_after_ic8", perr, 0);

    // Contention on the first cycle out of reset
    reset = 1;
    @(negedge clk); @(negedge clk);
    set_req(0, 64'h1100, 0); set_req(1, 64'h2100, 0);
    reset = 0;
    #1 chk("c1_ic_win", {ic_arready, dc_arready}, 2'b10);
    @(negedge clk);
    ic_arvalid = 0;
    #1 chk("c1_dc_held", dc_arready, 0);
    addr_phase(0, 64'h1100, 0, 0);
    data_phase(0, 0);
    chk("c2_dc_win", {ic_arready, dc_arready}, 2'b01);
    @(negedge clk);
    dc_arvalid = 0;
    #1 addr_phase(1, 64'h2100, 0, 0);
    data_phase(1, 0);
    set_req(0, 64'h1200, 0); set_req(1, 64'h2200, 0);
    #1 chk("c3_ic_win", {ic_arready, dc_arready}, 2'b10);
    @(negedge clk);
    ic_arvalid = 0; dc_arvalid = 0;
    #1 addr_phase(0, 64'h1200, 0, 0);
    data_phase(0, 0);

    // I-cache stalls for 3 cycles after beat 1 of 4
    set_req(0, 64'h1300, 3);
    @(negedge clk);
    ic_arvalid = 0;
    #1 addr_phase(0, 64'h1300, 3, 0);
    m_axi_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      m_axi_rdata = 64'hB000 + 64'(i); m_axi_rlast = (i == 3);
      if (i == 2) begin
        ic_rready = 0;
        for (int s = 0; s < 3; s++) begin
          #1 chk("stall_rready", m_axi_rready, 0);
          chk("stall_rdata", ic_rdata, 64'hB002);
          @(negedge clk);
        end
      end
      ic_rready = 1;
      #1 chk("stall_beat", {m_axi_rready, ic_rvalid, ic_rlast}, {2'b11, (i == 3)});
      chk("stall_data", ic_rdata, 64'hB000 + 64'(i));
      @(negedge clk);
    end
    m_axi_rvalid = 0; m_axi_rlast = 0; ic_rready = 0;
    #1 chk("stall_done", {icr, perr}, 0);

    // Early rlast: arlen=3, rlast on the second beat
    set_req(0, 64'h1400, 3);
    @(negedge clk);
    ic_arvalid = 0;
    #1 addr_phase(0, 64'h1400, 3, 0);
    data_phase(0, 1);
    chk("early_err", perr, 1);
    run_burst(1, 64'h2400, 1, 0);
    chk("err_sticky", perr, 1);
    do_reset();
    #1 chk("err_cleared", perr, 0);

    // Reset in DATA after 2 of 8 beats
    set_req(1, 64'h2500, 7);
    @(negedge clk);
    dc_arvalid = 0;
    #1 addr_phase(1, 64'h2500, 7, 0);
    dc_rready = 1; m_axi_rvalid = 1;
    @(negedge clk); @(negedge clk);
    reset = 1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    reset = 0; m_axi_rvalid = 0; dc_rready = 0;
    #1 chk_all_zero("post_reset");
    run_burst(1, 64'h2600, 1, 0);
    chk("post_reset_err", perr, 0);

    // Single-beat D-cache read with AR accepted after 4 wait cycles
    run_burst(1, 64'h2700, 0, 4);
    chk("single_err", perr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 64, address bus width; DATA_WIDTH, 64, read data width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1: clock; one clock, all state on rising edge.
- reset in 1: synchronous, active-high reset.
- ic_arvalid in 1: I-cache read request.
- ic_araddr in ADDR_WIDTH: I-cache burst address.
- ic_arlen in 8: I-cache burst length.
- ic_arsize in 3: I-cache beat size.
- ic_arburst in 2: I-cache burst type.
- ic_arready out 1: I-cache request accepted.
- ic_rvalid out 1: beat valid to I-cache.
- ic_rlast out 1: last beat to I-cache.
- ic_rdata out DATA_WIDTH: beat data to I-cache.
- ic_rready in 1: I-cache accepts beat.
- dc_arvalid, dc_araddr, dc_arlen, dc_arsize, dc_arburst, dc_arready, dc_rvalid, dc_rlast, dc_rdata, dc_rready: D-cache equivalents, same directions and widths.
- m_axi_arvalid out 1, m_axi_araddr out ADDR_WIDTH, m_axi_arlen out 8, m_axi_arsize out 3, m_axi_arburst out 2: shared AR channel.
- m_axi_arready in 1: AR accepted by memory.
- m_axi_rvalid in 1, m_axi_rlast in 1, m_axi_rdata in DATA_WIDTH: shared R channel.
- m_axi_rready out 1: shared R-channel ready.
- instruction_cache_reading out 1: I-cache owns the bus.
- data_cache_reading out 1: D-cache owns the bus.
- protocol_error out 1: sticky burst-length mismatch flag.

Function
REQ-003 FSM states SHALL be IDLE, ADDR, DATA; one burst in flight at a time.
REQ-004 In IDLE, the arbiter SHALL sample both arvalid inputs each cycle; no request -> stay IDLE.
REQ-005 Single requester SHALL win. Both requesting -> winner is the one not granted last (round-robin); last_grant resets to D-cache, so the first contested grant goes to the I-cache.
REQ-006 In the IDLE grant cycle, the winner's arready SHALL be 1 for exactly that cycle (combinational). The loser's arready SHALL be 0. Winner's araddr/arlen/arsize/arburst SHALL be registered. FSM -> ADDR.
REQ-007 In ADDR, m_axi_arvalid SHALL be 1 with registered fields held stable. On m_axi_arready=1: FSM -> DATA, beat counter loads arlen.
REQ-008 Latency: requester arvalid sampled in IDLE at cycle N -> m_axi_arvalid high at cycle N+1.
REQ-009 In DATA, the owner's rvalid/rlast/rdata SHALL equal the m_axi values combinationally, and m_axi_rready SHALL equal the owner's rready. The non-owner's rvalid and rlast SHALL be 0.
REQ-010 A beat is accepted when m_axi_rvalid & m_axi_rready. Each accepted beat without rlast SHALL decrement the counter (8-bit, no wrap below 0).
REQ-011 Accepted beat with rlast SHALL move FSM -> IDLE and update last_grant to the owner.
REQ-012 protocol_error SHALL set and stay set until reset when either:
- rlast is accepted with counter != 0; or
- a beat is accepted without rlast while counter == 0.
REQ-013 The FSM SHALL still terminate on rlast in the mismatch case.
REQ-014 instruction_cache_reading / data_cache_reading SHALL be 1 from ADDR entry through the cycle of the final accepted beat. They are mutually exclusive and both 0 in IDLE.
REQ-015 Requests arriving during ADDR/DATA SHALL NOT be accepted. A request coincident with the rlast beat SHALL be granted no earlier than the following IDLE cycle (minimum one IDLE cycle between bursts).
REQ-016 A requester that deasserts arvalid before grant SHALL be ignored and no state retained.
REQ-017 arlen=0 (single beat) SHALL complete normally: rlast on the first beat, no error.

Reset
REQ-018 With reset=1 at a clock edge, FSM SHALL go to IDLE and last_grant to D-cache. All registered fields, the counter and protocol_error SHALL clear.
REQ-019 While reset=1, all outputs SHALL be 0, including m_axi_rready and both arready. Reset mid-burst abandons the burst; memory is reset by the same signal.

Verification
REQ-020 Bench SHALL cover:
- I-cache only, araddr=0x1000, arlen=7 -> m_axi_arvalid at N+1; 8 beats routed to ic_*; dc_rvalid=0 throughout; instruction_cache_reading high for the burst; back to IDLE.
- Both request at reset-exit cycle -> I-cache granted first; D-cache held off, then granted after one IDLE cycle; third contested round -> I-cache.
- I-cache rready low for 3 cycles mid-burst -> m_axi_rready low for those cycles; counter unchanged; all beats delivered in order.
- arlen=3 but rlast on beat 2 -> protocol_error=1, FSM IDLE, error persists until reset.
- Reset asserted in DATA after beat 2 of 8 -> next cycle all outputs 0, IDLE; a new D-cache request is then granted normally.
- arlen=0 D-cache read with m_axi_arready delayed 4 cycles -> m_axi_arvalid held with stable address; one beat delivered; no error.
